// File: rtl/d_mem_ctl_if.sv
// Request/acknowledge bundle between the core's data port and the tape memory controller.
// The core drives through the master modport; the controller serves the slave modport.
interface d_mem_ctl_if #(
  parameter int unsigned D_ADDR_WIDTH = 8,
  parameter int unsigned D_DATA_WIDTH = 8
) ();

  logic                    d_req;
  logic                    d_dir;
  logic [D_ADDR_WIDTH-1:0] d_addr;
  logic [D_DATA_WIDTH-1:0] d_wdata;
  logic                    d_ack;
  logic [D_DATA_WIDTH-1:0] d_rdata;
  logic                    d_err;
  logic                    busy;

  modport master (
    output d_req, d_dir, d_addr, d_wdata,
    input  d_ack, d_rdata, d_err, busy
  );

  modport slave (
    input  d_req, d_dir, d_addr, d_wdata,
    output d_ack, d_rdata, d_err, busy
  );

endinterface

// File: rtl/d_mem_ctl.sv
// Data-memory controller for the BF tape: single-port RAM behind a req/ack handshake,
// with configurable wait states, optional zero sweep after reset and out-of-range flagging.
module d_mem_ctl #(
  parameter int unsigned D_ADDR_WIDTH   = 8,
  parameter int unsigned D_DATA_WIDTH   = 8,
  parameter int unsigned D_MEM_LENGTH   = 64,
  parameter int unsigned WAIT_STATES    = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  d_mem_ctl_if.slave   bus
);

  if (D_MEM_LENGTH > (64'd1 << D_ADDR_WIDTH)) begin : g_len_check
    $error("D_MEM_LENGTH exceeds the address space of D_ADDR_WIDTH");
  end
  if (WAIT_STATES > 15) begin : g_wait_check
    $error("WAIT_STATES must be in 0..15");
  end

  localparam int unsigned IdxW = (D_MEM_LENGTH > 1) ? $clog2(D_MEM_LENGTH) : 1;
  localparam logic [D_ADDR_WIDTH:0]   MemLen   = (D_ADDR_WIDTH + 1)'(D_MEM_LENGTH);
  localparam logic [D_ADDR_WIDTH-1:0] LastAddr = D_ADDR_WIDTH'(D_MEM_LENGTH - 1);
  localparam logic [3:0] WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {StClear, StIdle, StWait, StCommit, StDone} state_e;
  localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StIdle;

  logic [D_DATA_WIDTH-1:0] mem [D_MEM_LENGTH];

  state_e                  state_q, state_d;
  logic [D_ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic                    dir_q, dir_d;
  logic [D_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [D_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [D_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                    derr_q, derr_d;
  logic                    busy_q, busy_d;

  logic                    mem_we;
  logic [IdxW-1:0]         mem_idx;
  logic [D_DATA_WIDTH-1:0] mem_wd;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    derr_d     = derr_q;
    mem_we     = 1'b0;
    mem_idx    = addr_q[IdxW-1:0];
    mem_wd     = wdata_q;

    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_idx   = clr_ptr_q[IdxW-1:0];
        mem_wd    = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LastAddr) begin
          clr_ptr_d = '0;
          state_d   = StIdle;
        end
      end
      StIdle: begin
        if (bus.d_req) begin
          dir_d   = bus.d_dir;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          // Zero-extended compare so a full-size tape never flags an error.
          err_d   = ({1'b0, bus.d_addr} >= MemLen);
          if (WAIT_STATES > 0) begin
            wait_cnt_d = WaitInit;
            state_d    = StWait;
          end else begin
            state_d    = StCommit;
          end
        end
      end
      StWait: begin
        if (!bus.d_req) begin
          state_d = StIdle;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = StCommit;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StCommit: begin
        // A write commits even if the requester has already withdrawn.
        mem_we = dir_q & ~err_q;
        if (!dir_q) begin
          rdata_d = err_q ? '0 : mem[mem_idx];
        end
        derr_d  = err_q;
        state_d = bus.d_req ? StDone : StIdle;
      end
      StDone: begin
        if (!bus.d_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StClear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ResetState;
      clr_ptr_q  <= '0;
      wait_cnt_q <= '0;
      dir_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      derr_q     <= 1'b0;
      busy_q     <= CLEAR_ON_RESET;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      derr_q     <= derr_d;
      busy_q     <= busy_d;
    end
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wd;
    end
  end

  assign bus.d_ack   = (state_q == StDone) & bus.d_req;
  assign bus.d_rdata = rdata_q;
  assign bus.d_err   = derr_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_d_mem_ctl.sv
// Scoreboard bench for d_mem_ctl: driver pushes expected responses from a tape model,
// a monitor pops and compares on every rising d_ack.
module tb_d_mem_ctl;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned LEN = 64;
  localparam int unsigned WS  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  d_mem_ctl_if #(.D_ADDR_WIDTH(AW), .D_DATA_WIDTH(DW)) bus ();

  d_mem_ctl #(
    .D_ADDR_WIDTH  (AW),
    .D_DATA_WIDTH  (DW),
    .D_MEM_LENGTH  (LEN),
    .WAIT_STATES   (WS),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic          dir;
    logic [DW-1:0] rdata;
    logic          err;
    int            raise_cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [LEN];
  int            cyc    = 0;
  int            n_cmp  = 0;
  int            n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: every rising d_ack retires one expected response.
  initial begin
    exp_t e;
    logic ack_prev = 1'b0;
    logic req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.d_ack && !ack_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack_latency", 32'(cyc - e.raise_cyc), WS + 2);
            check("d_err", 32'(bus.d_err), 32'(e.err));
            if (!e.dir) check("d_rdata", 32'(bus.d_rdata), 32'(e.rdata));
          end
        end
        if (req_prev && !bus.d_req) check("ack_fall_with_req", 32'(bus.d_ack), 32'd0);
      end
      ack_prev = bus.d_ack;
      req_prev = bus.d_req;
    end
  end

  task automatic access(input logic dir, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int hold);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    bus.d_dir   = dir;
    bus.d_addr  = addr;
    bus.d_wdata = data;
    bus.d_req   = 1'b1;
    e.dir       = dir;
    e.err       = (int'(addr) >= int'(LEN));
    e.raise_cyc = cyc;
    e.rdata     = '0;
    if (!e.err) begin
      if (dir) ref_mem[addr] = data;
      else     e.rdata = ref_mem[addr];
    end
    exp_q.push_back(e);
    // Scramble the bus once the request has been sampled; the DUT must not care.
    @(posedge clk); #1;
    bus.d_dir   = ~dir;
    bus.d_addr  = AW'($urandom);
    bus.d_wdata = DW'($urandom);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.d_ack;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("ack_held", 32'(bus.d_ack), 32'd1);
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  // Write request withdrawn during the wait phase: no ack, no memory change.
  task automatic abort_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(posedge clk); #1;
    bus.d_dir   = 1'b1;
    bus.d_addr  = addr;
    bus.d_wdata = data;
    bus.d_req   = 1'b1;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    repeat (WS + 4) @(negedge clk);
  endtask

  task automatic reset_and_count_busy(input int abort_at);
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_ack", 32'(bus.d_ack), 32'd0);
    check("rst_err", 32'(bus.d_err), 32'd0);
    check("rst_rdata", 32'(bus.d_rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (!bus.busy) break;
    end
    check("busy_cycles", 32'(n), LEN);
    for (int i = 0; i < LEN; i++) ref_mem[i] = '0;
  endtask

  initial begin
    logic          dir;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bus.d_req   = 1'b0;
    bus.d_dir   = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    reset_and_count_busy(0);
    access(1'b0, 8'h3F, '0, 0);
    access(1'b1, 8'h10, 16'h00A5, 0);
    access(1'b0, 8'h10, '0, 0);
    access(1'b1, 8'h3F, 16'h1234, 0);
    access(1'b1, 8'h40, 16'h0077, 0);
    access(1'b0, 8'h40, '0, 0);
    access(1'b0, 8'h3F, '0, 0);
    access(1'b0, 8'hFF, '0, 0);
    access(1'b0, 8'h10, '0, 5);
    access(1'b1, 8'h20, 16'hBEEF, 0);
    access(1'b0, 8'h20, '0, 1);
    abort_write(8'h10, 16'h0055);
    access(1'b0, 8'h10, '0, 0);

    for (int i = 0; i < 40; i++) begin
      dir  = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 80));
      data = DW'($urandom);
      if ($urandom_range(0, 7) == 0) abort_write(addr, data);
      else access(dir, addr, data, $urandom_range(0, 2));
    end

    reset_and_count_busy(20);
    access(1'b0, 8'h00, '0, 0);
    access(1'b0, 8'h20, '0, 0);
    access(1'b0, 8'h3F, '0, 0);

    repeat (5) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

endmodule
